// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

  localparam int unsigned INSTR_BYTES      = 3;
  localparam int unsigned INSTR_W          = 8 * INSTR_BYTES;
  localparam int unsigned DEF_ADDR_W       = 16;
  localparam logic [15:0] DEF_RESET_VECTOR = 16'h0000;

  typedef enum logic [2:0] {
    IDLE,
    B0,
    B1,
    B2,
    HOLD,
    DRAIN
  } fetch_state_t;

  // Byte index within the instruction addressed in a given fetch state.
  function automatic logic [1:0] byte_offset(input fetch_state_t s);
    case (s)
      B1:      return 2'd1;
      B2:      return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic is_req_state(input fetch_state_t s);
    return (s == B0) || (s == B1) || (s == B2) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/instr_fetch_buf.sv
// One-entry prefetch buffer holding an assembled instruction and its address.
module instr_fetch_buf
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] raw_i,
  input  logic [ADDR_W-1:0]  ai_i,
  output logic [INSTR_W-1:0] raw_o,
  output logic [ADDR_W-1:0]  ai_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] raw_q;
  logic [ADDR_W-1:0]  ai_q;
  logic               valid_q;

  // Load beats pop so a refill in the same cycle as a pop keeps the entry valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_q   <= '0;
      ai_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      raw_q   <= raw_i;
      ai_q    <= ai_i;
      valid_q <= 1'b1;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign raw_o   = raw_q;
  assign ai_o    = ai_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: assembles 3 big-endian bytes into one instruction for the ecu.
// Optional INSTR_FETCH_PREFETCH_EN adds a one-entry buffer that fetches past a held instruction.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W       = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [7:0]         mem_rdata,
  input  logic               mem_ack,
  output logic [INSTR_W-1:0] raw,
  output logic [ADDR_W-1:0]  ai,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  ai_q, ai_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [7:0]         byte0_q, byte0_d;
  logic [7:0]         byte1_q, byte1_d;
  logic [INSTR_W-1:0] raw_q, raw_d;
  logic [INSTR_W-1:0] new_raw_c;
  logic               valid_q, valid_d;
  logic               mem_req_q, mem_req_d;
  logic               ack_c, xfer_c, done_c, cont_c, resume_c;

  assign ack_c     = mem_req_q & mem_ack;
  assign xfer_c    = valid_q & instr_ready;
  assign done_c    = (state_q == B2) & ack_c & ~redirect_valid;
  assign new_raw_c = {byte0_q, byte1_q, mem_rdata};

`ifdef INSTR_FETCH_PREFETCH_EN
  logic               buf_load_c, buf_pop_c, buf_flush_c, buf_valid;
  logic [INSTR_W-1:0] buf_raw;
  logic [ADDR_W-1:0]  buf_ai;

  instr_fetch_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load_c),
    .pop_i   (buf_pop_c),
    .flush_i (buf_flush_c),
    .raw_i   (new_raw_c),
    .ai_i    (pc_q),
    .raw_o   (buf_raw),
    .ai_o    (buf_ai),
    .valid_o (buf_valid)
  );

  // Keep fetching while output + buffer will still have a free slot.
  assign cont_c   = ~buf_valid & (~valid_q | xfer_c);
  assign resume_c = ~buf_valid | xfer_c;
`else
  assign cont_c   = 1'b0;
  assign resume_c = xfer_c;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Redirect overrides everything; an unacked request must finish in DRAIN first.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = (mem_req_q && !mem_ack) ? DRAIN : B0;
    end else begin
      case (state_q)
        IDLE:    state_d = B0;
        B0:      if (ack_c) state_d = B1;
        B1:      if (ack_c) state_d = B2;
        B2:      if (ack_c) state_d = cont_c ? B0 : HOLD;
        HOLD:    if (resume_c) state_d = B0;
        DRAIN:   if (ack_c) state_d = B0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pc_d    = pc_q;
    byte0_d = byte0_q;
    byte1_d = byte1_q;
    raw_d   = raw_q;
    ai_d    = ai_q;
    valid_d = valid_q & ~xfer_c;
`ifdef INSTR_FETCH_PREFETCH_EN
    buf_load_c  = 1'b0;
    buf_pop_c   = 1'b0;
    buf_flush_c = redirect_valid;
`endif
    if (ack_c && state_q == B0) byte0_d = mem_rdata;
    if (ack_c && state_q == B1) byte1_d = mem_rdata;

    if (redirect_valid) begin
      pc_d    = redirect_addr;
      valid_d = 1'b0;
    end else begin
      if (done_c) pc_d = pc_q + ADDR_W'(INSTR_BYTES);
`ifdef INSTR_FETCH_PREFETCH_EN
      // Output slot frees up: refill from buffer first, else from the fresh fetch.
      if (!valid_q || xfer_c) begin
        if (buf_valid) begin
          raw_d      = buf_raw;
          ai_d       = buf_ai;
          valid_d    = 1'b1;
          buf_pop_c  = 1'b1;
          buf_load_c = done_c;
        end else if (done_c) begin
          raw_d   = new_raw_c;
          ai_d    = pc_q;
          valid_d = 1'b1;
        end
      end else if (done_c) begin
        buf_load_c = 1'b1;
      end
`else
      if (done_c) begin
        raw_d   = new_raw_c;
        ai_d    = pc_q;
        valid_d = 1'b1;
      end
`endif
    end

    // Address stays frozen in DRAIN so the outstanding request is not disturbed.
    mem_req_d  = is_req_state(state_d);
    mem_addr_d = (state_d == DRAIN) ? mem_addr_q
                                    : pc_d + ADDR_W'(byte_offset(state_d));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_VECTOR;
      mem_addr_q <= RESET_VECTOR;
      mem_req_q  <= 1'b0;
      byte0_q    <= '0;
      byte1_q    <= '0;
      raw_q      <= '0;
      ai_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      byte0_q    <= byte0_d;
      byte1_q    <= byte1_d;
      raw_q      <= raw_d;
      ai_q       <= ai_d;
      valid_q    <= valid_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign raw         = raw_q;
  assign ai          = ai_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a byte memory model and configurable wait states.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [23:0] raw;
  logic [15:0] ai;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [15:0] redirect_addr;

  logic [7:0]  mem [0:65535];
  int          waits;
  int          wcnt;
  logic        ack_block;
  int          checks;
  int          failures;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .raw            (raw),
    .ai             (ai),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && !ack_block && (wcnt >= waits);

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 16'h0000;
    ack_block      = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst            = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 16'h0000;
    ack_block      = 1'b0;
    waits          = 0;
    repeat (2) tick();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
    checks++; if (raw !== 24'h0) begin failures++; $display("FAIL reset_raw got=%h exp=000000", raw); end
    checks++; if (ai !== 16'h0) begin failures++; $display("FAIL reset_ai got=%h exp=0000", ai); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
  endtask

  task automatic test_basic_stall();
    waits       = 0;
    instr_ready = 1'b0;
    apply_reset();
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if ({mem_req, mem_addr, instr_valid} !== {1'b1, 16'(c - 1), 1'b0}) begin
        failures++; $display("FAIL basic_fetch_c%0d got req=%b addr=%h vld=%b exp req=1 addr=%h vld=0", c, mem_req, mem_addr, instr_valid, 16'(c - 1));
      end
    end
    tick();
    checks++;
    if ({instr_valid, mem_req, ai, raw} !== {1'b1, 1'b0, 16'h0000, 24'hA1B2C3}) begin
      failures++; $display("FAIL basic_first_instr got vld=%b req=%b ai=%h raw=%h exp vld=1 req=0 ai=0000 raw=a1b2c3", instr_valid, mem_req, ai, raw);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({instr_valid, mem_req, ai, raw} !== {1'b1, 1'b0, 16'h0000, 24'hA1B2C3}) begin
        failures++; $display("FAIL stall_hold_%0d got vld=%b req=%b ai=%h raw=%h exp vld=1 req=0 ai=0000 raw=a1b2c3", c, instr_valid, mem_req, ai, raw);
      end
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if ({mem_req, mem_addr, instr_valid} !== {1'b1, 16'h0003, 1'b0}) begin
      failures++; $display("FAIL stall_release got req=%b addr=%h vld=%b exp req=1 addr=0003 vld=0", mem_req, mem_addr, instr_valid);
    end
    repeat (3) tick();
    checks++;
    if ({instr_valid, ai, raw} !== {1'b1, 16'h0003, 24'hD4E5F6}) begin
      failures++; $display("FAIL basic_second_instr got vld=%b ai=%h raw=%h exp vld=1 ai=0003 raw=d4e5f6", instr_valid, ai, raw);
    end
    tick();
    checks++;
    if ({mem_req, mem_addr, instr_valid} !== {1'b1, 16'h0006, 1'b0}) begin
      failures++; $display("FAIL basic_third_fetch got req=%b addr=%h vld=%b exp req=1 addr=0006 vld=0", mem_req, mem_addr, instr_valid);
    end
  endtask

  task automatic test_wait_states();
    waits       = 2;
    instr_ready = 1'b0;
    apply_reset();
    for (int c = 1; c <= 9; c++) begin
      tick();
      checks++;
      if ({mem_req, mem_addr, instr_valid} !== {1'b1, 16'((c - 1) / 3), 1'b0}) begin
        failures++; $display("FAIL wait_c%0d got req=%b addr=%h vld=%b exp req=1 addr=%h vld=0", c, mem_req, mem_addr, instr_valid, 16'((c - 1) / 3));
      end
    end
    tick();
    checks++;
    if ({instr_valid, ai, raw} !== {1'b1, 16'h0000, 24'hA1B2C3}) begin
      failures++; $display("FAIL wait_valid_c10 got vld=%b ai=%h raw=%h exp vld=1 ai=0000 raw=a1b2c3", instr_valid, ai, raw);
    end
    waits = 0;
  endtask

  task automatic test_redirect_drain();
    waits       = 0;
    instr_ready = 1'b1;
    apply_reset();
    tick();
    tick();
    ack_block      = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({mem_req, mem_addr, instr_valid} !== {1'b1, 16'h0001, 1'b0}) begin
      failures++; $display("FAIL drain_hold_addr got req=%b addr=%h vld=%b exp req=1 addr=0001 vld=0", mem_req, mem_addr, instr_valid);
    end
    tick();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0001}) begin
      failures++; $display("FAIL drain_wait_ack got req=%b addr=%h exp req=1 addr=0001", mem_req, mem_addr);
    end
    ack_block = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({mem_req, mem_addr, instr_valid} !== {1'b1, 16'h0040 + 16'(c), 1'b0}) begin
        failures++; $display("FAIL redirect_fetch_%0d got req=%b addr=%h vld=%b exp req=1 addr=%h vld=0", c, mem_req, mem_addr, instr_valid, 16'h0040 + 16'(c));
      end
    end
    tick();
    checks++;
    if ({instr_valid, ai, raw} !== {1'b1, 16'h0040, 24'h5A6B7C}) begin
      failures++; $display("FAIL redirect_instr got vld=%b ai=%h raw=%h exp vld=1 ai=0040 raw=5a6b7c", instr_valid, ai, raw);
    end
  endtask

  task automatic test_wrap();
    waits       = 0;
    instr_ready = 1'b1;
    apply_reset();
    redirect_valid = 1'b1;
    redirect_addr  = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'hFFFE}) begin
      failures++; $display("FAIL wrap_b0 got req=%b addr=%h exp req=1 addr=fffe", mem_req, mem_addr);
    end
    tick();
    checks++;
    if (mem_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_b1 got addr=%h exp ffff", mem_addr); end
    tick();
    checks++;
    if (mem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_b2 got addr=%h exp 0000", mem_addr); end
    tick();
    checks++;
    if ({instr_valid, ai, raw} !== {1'b1, 16'hFFFE, 24'h0102A1}) begin
      failures++; $display("FAIL wrap_instr got vld=%b ai=%h raw=%h exp vld=1 ai=fffe raw=0102a1", instr_valid, ai, raw);
    end
`ifndef INSTR_FETCH_PREFETCH_EN
    tick();
`endif
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0001}) begin
      failures++; $display("FAIL wrap_next_pc got req=%b addr=%h exp req=1 addr=0001", mem_req, mem_addr);
    end
  endtask

  task automatic test_reset_mid();
    waits       = 0;
    instr_ready = 1'b1;
    apply_reset();
    repeat (3) tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_req, instr_valid, mem_addr} !== {1'b0, 1'b0, 16'h0000}) begin
      failures++; $display("FAIL reset_mid_async got req=%b vld=%b addr=%h exp req=0 vld=0 addr=0000", mem_req, instr_valid, mem_addr);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
      failures++; $display("FAIL reset_mid_restart got req=%b addr=%h exp req=1 addr=0000", mem_req, mem_addr);
    end
  endtask

`ifdef INSTR_FETCH_PREFETCH_EN
  task automatic test_prefetch();
    waits       = 0;
    instr_ready = 1'b1;
    apply_reset();
    repeat (4) tick();
    checks++;
    if ({instr_valid, ai, mem_req, mem_addr} !== {1'b1, 16'h0000, 1'b1, 16'h0003}) begin
      failures++; $display("FAIL pf_first got vld=%b ai=%h req=%b addr=%h exp vld=1 ai=0000 req=1 addr=0003", instr_valid, ai, mem_req, mem_addr);
    end
    repeat (3) tick();
    checks++;
    if ({instr_valid, ai, raw, mem_addr} !== {1'b1, 16'h0003, 24'hD4E5F6, 16'h0006}) begin
      failures++; $display("FAIL pf_second got vld=%b ai=%h raw=%h addr=%h exp vld=1 ai=0003 raw=d4e5f6 addr=0006", instr_valid, ai, raw, mem_addr);
    end
    repeat (3) tick();
    checks++;
    if ({instr_valid, ai, raw, mem_addr} !== {1'b1, 16'h0006, 24'h112233, 16'h0009}) begin
      failures++; $display("FAIL pf_third got vld=%b ai=%h raw=%h addr=%h exp vld=1 ai=0006 raw=112233 addr=0009", instr_valid, ai, raw, mem_addr);
    end
    instr_ready = 1'b0;
    repeat (3) tick();
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({mem_req, instr_valid, ai} !== {1'b0, 1'b1, 16'h0006}) begin
        failures++; $display("FAIL pf_stall_%0d got req=%b vld=%b ai=%h exp req=0 vld=1 ai=0006", c, mem_req, instr_valid, ai);
      end
      if (c == 0) tick();
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if ({instr_valid, ai, raw, mem_req, mem_addr} !== {1'b1, 16'h0009, 24'h9AABBC, 1'b1, 16'h000C}) begin
      failures++; $display("FAIL pf_buffered got vld=%b ai=%h raw=%h req=%b addr=%h exp vld=1 ai=0009 raw=9aabbc req=1 addr=000c", instr_valid, ai, raw, mem_req, mem_addr);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    waits    = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEE;
    mem[16'h0000] = 8'hA1; mem[16'h0001] = 8'hB2; mem[16'h0002] = 8'hC3;
    mem[16'h0003] = 8'hD4; mem[16'h0004] = 8'hE5; mem[16'h0005] = 8'hF6;
    mem[16'h0006] = 8'h11; mem[16'h0007] = 8'h22; mem[16'h0008] = 8'h33;
    mem[16'h0009] = 8'h9A; mem[16'h000A] = 8'hAB; mem[16'h000B] = 8'hBC;
    mem[16'h0040] = 8'h5A; mem[16'h0041] = 8'h6B; mem[16'h0042] = 8'h7C;
    mem[16'hFFFE] = 8'h01; mem[16'hFFFF] = 8'h02;

    test_reset();
`ifdef INSTR_FETCH_PREFETCH_EN
    test_prefetch();
`else
    test_basic_stall();
`endif
    test_wait_states();
    test_redirect_drain();
    test_wrap();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
